// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: MIPS memory-access stage driving an SRAM-like addr_ok/data_ok bus.
// Optional MEM_ADDR_EXC_EN: misaligned accesses raise mem_adel/mem_ades. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ex_wd,
  input  logic              ex_reg,
  input  logic [31:0]       ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [31:0]       ex_maddr,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic              flush,
  output logic              stallreq,
  output logic [4:0]        mem_wd,
  output logic              mem_reg,
  output logic [31:0]       mem_wdata,
`ifdef MEM_ADDR_EXC_EN
  output logic              mem_adel,
  output logic              mem_ades,
`endif
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t      state;
  state_t      next_state;
  logic        is_load;
  logic        is_store;
  logic [1:0]  op_size;
  logic        misalign;
  logic [31:0] bus_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        req;
`ifdef MEM_ADDR_EXC_EN
  logic        exc_load;
  logic        exc_store;
`endif

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    op_size  = SZ_BYTE;
    case (ex_memop)
      OP_LB, OP_LBU: begin is_load  = 1'b1; op_size = SZ_BYTE; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; op_size = SZ_HALF; end
      OP_LW:         begin is_load  = 1'b1; op_size = SZ_WORD; end
      OP_SB:         begin is_store = 1'b1; op_size = SZ_BYTE; end
      OP_SH:         begin is_store = 1'b1; op_size = SZ_HALF; end
      OP_SW:         begin is_store = 1'b1; op_size = SZ_WORD; end
      default:       ;
    endcase
  end

`ifdef MEM_ADDR_EXC_EN
  assign misalign = ((op_size == SZ_HALF) && ex_maddr[0]) ||
                    ((op_size == SZ_WORD) && (ex_maddr[1:0] != 2'b00));
  assign bus_addr = ex_maddr;
`else
  // Without the exception path, misaligned accesses are silently aligned.
  assign misalign = 1'b0;
  always_comb begin
    bus_addr = ex_maddr;
    if (op_size == SZ_HALF)
      bus_addr[0] = 1'b0;
    else if (op_size == SZ_WORD)
      bus_addr[1:0] = 2'b00;
  end
`endif

  always_comb begin
    case (op_size)
      SZ_BYTE: store_data = {4{ex_sdata[7:0]}};
      SZ_HALF: store_data = {2{ex_sdata[15:0]}};
      default: store_data = ex_sdata;
    endcase
  end

  // Little-endian lane selection; ex_* is held stable by stallreq while in DATA.
  always_comb begin
    case (ex_maddr[1:0])
      2'd0:    lane_b = data_rdata[7:0];
      2'd1:    lane_b = data_rdata[15:8];
      2'd2:    lane_b = data_rdata[23:16];
      default: lane_b = data_rdata[31:24];
    endcase
    lane_h = ex_maddr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (ex_memop)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'd0, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'd0, lane_h};
      default: load_data = data_rdata;
    endcase
  end

  always_comb begin
    next_state = state;
    stallreq   = 1'b0;
    mem_reg    = 1'b0;
    mem_wd     = ex_wd;
    mem_wdata  = ex_wdata;
    req        = 1'b0;
`ifdef MEM_ADDR_EXC_EN
    exc_load   = 1'b0;
    exc_store  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (flush) begin
            next_state = IDLE;
          end else if (misalign) begin
`ifdef MEM_ADDR_EXC_EN
            exc_load  = is_load;
            exc_store = is_store;
`endif
            next_state = IDLE;
          end else begin
            req        = 1'b1;
            stallreq   = 1'b1;
            next_state = data_addr_ok ? DATA : ADDR;
          end
        end else begin
          mem_reg = ex_reg & ~flush;
        end
      end
      ADDR: begin
        req      = 1'b1;
        stallreq = 1'b1;
        // Once accepted, a flushed request must still be drained.
        if (data_addr_ok)
          next_state = flush ? DRAIN : DATA;
        else if (flush)
          next_state = IDLE;
      end
      DATA: begin
        stallreq = 1'b1;
        if (data_data_ok) begin
          stallreq   = 1'b0;
          next_state = IDLE;
          if (is_load && !flush) begin
            mem_reg   = ex_reg;
            mem_wdata = load_data;
          end
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (data_data_ok)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (!rst) begin
      next_state = IDLE;
      stallreq   = 1'b0;
      mem_reg    = 1'b0;
      mem_wd     = 5'd0;
      mem_wdata  = 32'd0;
      req        = 1'b0;
`ifdef MEM_ADDR_EXC_EN
      exc_load   = 1'b0;
      exc_store  = 1'b0;
`endif
    end
  end

  assign data_req   = req;
  assign data_wr    = req & is_store;
  assign data_size  = req ? op_size : 2'd0;
  assign data_addr  = req ? bus_addr[ADDR_W-1:0] : '0;
  assign data_wdata = (req && is_store) ? store_data : '0;
`ifdef MEM_ADDR_EXC_EN
  assign mem_adel   = exc_load;
  assign mem_ades   = exc_store;
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed bench for mem_stage with a write-back scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_reg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_maddr;
  logic [31:0] ex_sdata;
  logic        flush;
  logic        stallreq;
  logic [4:0]  mem_wd;
  logic        mem_reg;
  logic [31:0] mem_wdata;
`ifdef MEM_ADDR_EXC_EN
  logic        mem_adel;
  logic        mem_ades;
`endif
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  typedef struct packed {
    logic [4:0]  wd;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  stall_cnt;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_reg(ex_reg), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
    .ex_maddr(ex_maddr), .ex_sdata(ex_sdata), .flush(flush),
    .stallreq(stallreq), .mem_wd(mem_wd), .mem_reg(mem_reg), .mem_wdata(mem_wdata),
`ifdef MEM_ADDR_EXC_EN
    .mem_adel(mem_adel), .mem_ades(mem_ades),
`endif
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input string tag);
    wb_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_reg"}, 32'(mem_reg), 32'd1);
      chk({tag, "_wd"}, 32'(mem_wd), 32'(e.wd));
      chk({tag, "_wdata"}, mem_wdata, e.data);
    end
  endtask

  task automatic drive_alu(input logic [4:0] wd, input logic rg, input logic [31:0] wdata);
    ex_memop = 4'd0; ex_wd = wd; ex_reg = rg; ex_wdata = wdata;
    ex_maddr = 32'h0; ex_sdata = 32'h0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic drive_mem(input logic [3:0] op, input logic [4:0] wd, input logic rg,
                           input logic [31:0] addr, input logic [31:0] sdata);
    ex_memop = op; ex_wd = wd; ex_reg = rg; ex_wdata = 32'h0BAD_0BAD;
    ex_maddr = addr; ex_sdata = sdata; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  initial begin
    // Reset with a busy-looking instruction present: outputs must stay zero.
    rst = 1'b0;
    drive_mem(4'd5, 5'd5, 1'b1, 32'h40, 32'h0);
    ex_wdata = 32'hDEAD;
    data_addr_ok = 1'b1;
    data_rdata = 32'h0;
    tick(); tick();
    chk("rst_stall", 32'(stallreq), 32'd0);
    chk("rst_reg",   32'(mem_reg), 32'd0);
    chk("rst_req",   32'(data_req), 32'd0);
    chk("rst_wd",    32'(mem_wd), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr",  data_addr, 32'd0);

    // ALU pass-through
    tick(); rst = 1'b1;
    drive_alu(5'd5, 1'b1, 32'h1234);
    sb_q.push_back('{wd: 5'd5, data: 32'h1234});
    #1;
    chk("alu_stall", 32'(stallreq), 32'd0);
    expect_wb("alu");

    // LB, addr_ok immediate, data_ok on the third cycle after issue
    tick();
    drive_mem(4'd1, 5'd7, 1'b1, 32'h103, 32'h0);
    data_addr_ok = 1'b1;
    sb_q.push_back('{wd: 5'd7, data: 32'hFFFF_FF80});
    stall_cnt = 0;
    #1;
    chk("lb_req",  32'(data_req), 32'd1);
    chk("lb_addr", data_addr, 32'h103);
    chk("lb_size", 32'(data_size), 32'd0);
    chk("lb_wr",   32'(data_wr), 32'd0);
    chk("lb_reg0", 32'(mem_reg), 32'd0);
    if (stallreq) stall_cnt++;
    tick(); data_addr_ok = 1'b0; #1;
    chk("lb_req_data", 32'(data_req), 32'd0);
    if (stallreq) stall_cnt++;
    tick(); #1;
    if (stallreq) stall_cnt++;
    tick(); data_data_ok = 1'b1; data_rdata = 32'h80FF_0000; #1;
    chk("lb_stall_done", 32'(stallreq), 32'd0);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    expect_wb("lb");

    // LHU with addr_ok delayed three cycles
    tick();
    drive_mem(4'd4, 5'd9, 1'b1, 32'h102, 32'h0);
    sb_q.push_back('{wd: 5'd9, data: 32'h0000_BEEF});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      data_addr_ok = (i == 3);
      #1;
      chk("lhu_req",  32'(data_req), 32'd1);
      chk("lhu_addr", data_addr, 32'h102);
      chk("lhu_size", 32'(data_size), 32'd1);
    end
    tick(); data_addr_ok = 1'b0; #1;
    chk("lhu_req_data", 32'(data_req), 32'd0);
    chk("lhu_stall_data", 32'(stallreq), 32'd1);
    tick(); data_data_ok = 1'b1; data_rdata = 32'hBEEF_1234; #1;
    chk("lhu_stall_done", 32'(stallreq), 32'd0);
    expect_wb("lhu");

    // SB byte replication
    tick();
    drive_mem(4'd6, 5'd0, 1'b0, 32'h1, 32'h0000_00A5);
    data_addr_ok = 1'b1;
    #1;
    chk("sb_req",   32'(data_req), 32'd1);
    chk("sb_wr",    32'(data_wr), 32'd1);
    chk("sb_size",  32'(data_size), 32'd0);
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
    chk("sb_reg_done",   32'(mem_reg), 32'd0);
    chk("sb_stall_done", 32'(stallreq), 32'd0);

    // SH flushed while waiting for addr_ok
    tick();
    drive_mem(4'd7, 5'd0, 1'b0, 32'h6, 32'h1234_BEEF);
    #1;
    chk("sh_wdata", data_wdata, 32'hBEEF_BEEF);
    chk("sh_size",  32'(data_size), 32'd1);
    chk("sh_addr",  data_addr, 32'h6);
    tick(); flush = 1'b1; #1;
    chk("sh_flush_req", 32'(data_req), 32'd1);
    tick();
    drive_alu(5'd4, 1'b1, 32'h77);
    sb_q.push_back('{wd: 5'd4, data: 32'h77});
    #1;
    chk("sh_after_req", 32'(data_req), 32'd0);
    expect_wb("sh_after");

    // LW flushed in DATA: drain while the next ALU op is treated as a bubble
    tick();
    drive_mem(4'd5, 5'd2, 1'b1, 32'h200, 32'h0);
    data_addr_ok = 1'b1;
    #1;
    chk("lw_req",  32'(data_req), 32'd1);
    chk("lw_size", 32'(data_size), 32'd2);
    tick(); data_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("lw_flush_stall", 32'(stallreq), 32'd1);
    tick();
    drive_alu(5'd3, 1'b1, 32'h55);
    #1;
    chk("drain_reg",   32'(mem_reg), 32'd0);
    chk("drain_req",   32'(data_req), 32'd0);
    chk("drain_stall", 32'(stallreq), 32'd0);
    tick(); data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; #1;
    chk("drain_done_reg", 32'(mem_reg), 32'd0);
    tick(); data_data_ok = 1'b0;
    sb_q.push_back('{wd: 5'd3, data: 32'h55});
    #1;
    expect_wb("post_drain");

    // Reset while in ADDR
    tick();
    drive_mem(4'd5, 5'd2, 1'b1, 32'h300, 32'h0);
    #1;
    chk("addr_rst_pre_req", 32'(data_req), 32'd1);
    tick(); rst = 1'b0; #1;
    chk("addr_rst_req",   32'(data_req), 32'd0);
    chk("addr_rst_stall", 32'(stallreq), 32'd0);
    chk("addr_rst_wdata", mem_wdata, 32'd0);
    tick(); rst = 1'b1;
    drive_alu(5'd6, 1'b1, 32'h99);
    sb_q.push_back('{wd: 5'd6, data: 32'h99});
    #1;
    chk("post_rst_req", 32'(data_req), 32'd0);
    expect_wb("post_rst");

`ifdef MEM_ADDR_EXC_EN
    // Misaligned LW raises an address-error pulse and issues nothing
    tick();
    drive_mem(4'd5, 5'd2, 1'b1, 32'h2, 32'h0);
    data_addr_ok = 1'b1;
    #1;
    chk("adel",       32'(mem_adel), 32'd1);
    chk("adel_ades",  32'(mem_ades), 32'd0);
    chk("adel_req",   32'(data_req), 32'd0);
    chk("adel_stall", 32'(stallreq), 32'd0);
    chk("adel_reg",   32'(mem_reg), 32'd0);
`else
    // Misaligned LH is aligned down and completes normally
    tick();
    drive_mem(4'd3, 5'd8, 1'b1, 32'h101, 32'h0);
    data_addr_ok = 1'b1;
    sb_q.push_back('{wd: 5'd8, data: 32'hFFFF_8001});
    #1;
    chk("lh_mis_addr", data_addr, 32'h100);
    chk("lh_mis_size", 32'(data_size), 32'd1);
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_8001; #1;
    expect_wb("lh_mis");
`endif

    tick();
    drive_alu(5'd0, 1'b0, 32'h0);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
